// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
//   aluop_t  : 3-bit operation code
//   shmode_t : shift flavour selected by Mode during SHF
//   state_t  : control FSM states
//   MODE_*   : bit positions within Mode when the op is CMP
package alu_pkg;

  typedef enum logic [2:0] {
    OP_MOV  = 3'b000,
    OP_PUT  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_SHF  = 3'b100,
    OP_CMP  = 3'b101,
    OP_FLIP = 3'b110,
    OP_ADC  = 3'b111
  } aluop_t;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shmode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // CMP: Mode[MODE_IMM] picks Num over DatB, Mode[MODE_SIGNED] picks two's-complement
  localparam int unsigned MODE_IMM    = 0;
  localparam int unsigned MODE_SIGNED = 1;

endpackage : alu_pkg

// File: rtl/seq_alu_if.sv
// Request/result bus of the sequential ALU.
//   master : request side (decode / testbench) drives operands and Out_ready
//   slave  : the ALU, returns In_ready, result, flags and Busy
interface seq_alu_if #(
  parameter int unsigned WIDTH = 8
);

  logic             In_valid;
  logic             In_ready;
  logic [2:0]       Aluop;
  logic [1:0]       Mode;
  logic [WIDTH-1:0] DatA;
  logic [WIDTH-1:0] DatB;
  logic [WIDTH-1:0] Num;
  logic [WIDTH-1:0] Num_to_put;
  logic             Out_valid;
  logic             Out_ready;
  logic [WIDTH-1:0] Rslt;
  logic             Grt;
  logic             Lss;
  logic             Eql;
  logic             Cry;
  logic             Busy;

  modport master (
    output In_valid, Aluop, Mode, DatA, DatB, Num, Num_to_put, Out_ready,
    input  In_ready, Out_valid, Rslt, Grt, Lss, Eql, Cry, Busy
  );

  modport slave (
    input  In_valid, Aluop, Mode, DatA, DatB, Num, Num_to_put, Out_ready,
    output In_ready, Out_valid, Rslt, Grt, Lss, Eql, Cry, Busy
  );

endinterface : seq_alu_if

// File: rtl/alu_shift_step.sv
// Combinational single-position shifter used once per SHIFT cycle.
//   mode    : LSL / LSR / ASR / ROR
//   val_i   : current partially shifted value
//   shift_c : value moved by exactly one bit position
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  shmode_t          mode,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] shift_c
);

  always_comb begin
    shift_c = val_i;
    unique case (mode)
      SH_LSL:  shift_c = {val_i[WIDTH-2:0], 1'b0};
      SH_LSR:  shift_c = {1'b0, val_i[WIDTH-1:1]};
      SH_ASR:  shift_c = {val_i[WIDTH-1], val_i[WIDTH-1:1]};
      SH_ROR:  shift_c = {val_i[0], val_i[WIDTH-1:1]};
      default: shift_c = val_i;
    endcase
  end

endmodule : alu_shift_step

// File: rtl/seq_alu.sv
// Registered ALU with persistent flags and iterative (1 bit/cycle) shifts.
//   Clk     : clock, all state on rising edge
//   Reset_n : synchronous active-low reset
//   bus     : seq_alu_if slave - valid/ready request in, valid/ready result out,
//             registered Rslt/Grt/Lss/Eql/Cry, Busy while shifting
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic      Clk,
  input  logic      Reset_n,
  seq_alu_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rslt_q, rslt_d;
  logic             out_valid_q, out_valid_d;
  logic             grt_q, grt_d;
  logic             lss_q, lss_d;
  logic             eql_q, eql_d;
  logic             cry_q, cry_d;
  logic [WIDTH-1:0] sh_val_q, sh_val_d;
  shmode_t          sh_mode_q, sh_mode_d;
  logic [SHW-1:0]   sh_cnt_q, sh_cnt_d;

  aluop_t           op_c;
  shmode_t          mode_c;
  logic             in_ready_c;
  logic             accept_c;
  logic [WIDTH:0]   add_c, sub_c, adc_c;
  logic [WIDTH-1:0] cmp_b_c, cmp_flip_c, cmp_ka_c, cmp_kb_c;
  logic [WIDTH-1:0] sh_n_c;
  logic [WIDTH-1:0] step_c;

  assign op_c       = aluop_t'(bus.Aluop);
  assign mode_c     = shmode_t'(bus.Mode);
  assign in_ready_c = (state_q == ST_IDLE) && (!out_valid_q || bus.Out_ready);
  assign accept_c   = bus.In_valid && in_ready_c;

  // Carry-out arithmetic; SUB carry of 1 means no borrow
  assign add_c = {1'b0, bus.DatA} + {1'b0, bus.DatB};
  assign sub_c = {1'b0, bus.DatA} + {1'b0, ~bus.DatB} + (WIDTH+1)'(1);
  assign adc_c = {1'b0, bus.DatA} + {1'b0, bus.DatB} + (WIDTH+1)'(cry_q);

  // Inverting both MSBs turns a signed compare into an unsigned one
  assign cmp_b_c    = bus.Mode[MODE_IMM] ? bus.Num : bus.DatB;
  assign cmp_flip_c = {bus.Mode[MODE_SIGNED], {(WIDTH-1){1'b0}}};
  assign cmp_ka_c   = bus.DatA ^ cmp_flip_c;
  assign cmp_kb_c   = cmp_b_c ^ cmp_flip_c;

  // Effective shift count: saturate at WIDTH for linear shifts, wrap for rotate
  always_comb begin
    if (mode_c == SH_ROR) begin
      sh_n_c = bus.DatB % WIDTH'(WIDTH);
    end else if (bus.DatB >= WIDTH'(WIDTH)) begin
      sh_n_c = WIDTH'(WIDTH);
    end else begin
      sh_n_c = bus.DatB;
    end
  end

  alu_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode    (sh_mode_q),
    .val_i   (sh_val_q),
    .shift_c (step_c)
  );

  // Next-state / datapath: counter holds remaining steps minus one so n=WIDTH fits SHW bits
  always_comb begin
    state_d     = state_q;
    rslt_d      = rslt_q;
    out_valid_d = out_valid_q && !bus.Out_ready;
    grt_d       = grt_q;
    lss_d       = lss_q;
    eql_d       = eql_q;
    cry_d       = cry_q;
    sh_val_d    = sh_val_q;
    sh_mode_d   = sh_mode_q;
    sh_cnt_d    = sh_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          out_valid_d = 1'b1;
          unique case (op_c)
            OP_MOV: rslt_d = bus.DatB;
            OP_PUT: rslt_d = bus.Num_to_put;
            OP_ADD: {cry_d, rslt_d} = add_c;
            OP_SUB: {cry_d, rslt_d} = sub_c;
            OP_ADC: {cry_d, rslt_d} = adc_c;
            OP_FLIP: begin
              rslt_d = ~bus.DatA;
              grt_d  = 1'b0;
              lss_d  = 1'b0;
              eql_d  = 1'b0;
            end
            OP_CMP: begin
              grt_d = cmp_ka_c > cmp_kb_c;
              lss_d = cmp_ka_c < cmp_kb_c;
              eql_d = cmp_ka_c == cmp_kb_c;
            end
            OP_SHF: begin
              if (sh_n_c == '0) begin
                rslt_d = bus.DatA;
              end else begin
                out_valid_d = 1'b0;
                state_d     = ST_SHIFT;
                sh_val_d    = bus.DatA;
                sh_mode_d   = mode_c;
                sh_cnt_d    = SHW'(sh_n_c - WIDTH'(1));
              end
            end
            default: rslt_d = rslt_q;
          endcase
        end
      end
      ST_SHIFT: begin
        sh_val_d = step_c;
        if (sh_cnt_q == '0) begin
          state_d     = ST_IDLE;
          rslt_d      = step_c;
          out_valid_d = 1'b1;
        end else begin
          sh_cnt_d = sh_cnt_q - SHW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      rslt_q      <= '0;
      out_valid_q <= 1'b0;
      grt_q       <= 1'b0;
      lss_q       <= 1'b0;
      eql_q       <= 1'b0;
      cry_q       <= 1'b0;
      sh_val_q    <= '0;
      sh_mode_q   <= SH_LSL;
      sh_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      rslt_q      <= rslt_d;
      out_valid_q <= out_valid_d;
      grt_q       <= grt_d;
      lss_q       <= lss_d;
      eql_q       <= eql_d;
      cry_q       <= cry_d;
      sh_val_q    <= sh_val_d;
      sh_mode_q   <= sh_mode_d;
      sh_cnt_q    <= sh_cnt_d;
    end
  end

  assign bus.In_ready  = in_ready_c;
  assign bus.Out_valid = out_valid_q;
  assign bus.Rslt      = rslt_q;
  assign bus.Grt       = grt_q;
  assign bus.Lss       = lss_q;
  assign bus.Eql       = eql_q;
  assign bus.Cry       = cry_q;
  assign bus.Busy      = (state_q == ST_SHIFT);

endmodule : seq_alu

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed scenarios plus random ops
// compared against a plain-arithmetic reference model.
module tb_seq_alu;

  localparam int unsigned W = 8;

  localparam logic [2:0] T_MOV  = 3'd0;
  localparam logic [2:0] T_PUT  = 3'd1;
  localparam logic [2:0] T_ADD  = 3'd2;
  localparam logic [2:0] T_SUB  = 3'd3;
  localparam logic [2:0] T_SHF  = 3'd4;
  localparam logic [2:0] T_CMP  = 3'd5;
  localparam logic [2:0] T_FLIP = 3'd6;
  localparam logic [2:0] T_ADC  = 3'd7;

  logic Clk;
  logic Reset_n;
  int   total;
  int   bad;

  // reference model state
  logic [W-1:0] m_rslt;
  logic         m_grt, m_lss, m_eql, m_cry;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_rslt = '0;
    m_grt  = 1'b0;
    m_lss  = 1'b0;
    m_eql  = 1'b0;
    m_cry  = 1'b0;
  endtask

  // Apply one operation to the model; lat = cycles from accept edge to Out_valid
  task automatic model_apply(input logic [2:0] op, input logic [1:0] md,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] num, input logic [W-1:0] put,
                             output int lat);
    int sum;
    int sh;
    int sa;
    int so;
    logic [W-1:0] nb;
    logic [W-1:0] o;
    lat = 1;
    nb  = ~b;
    case (op)
      T_MOV: m_rslt = b;
      T_PUT: m_rslt = put;
      T_ADD: begin
        sum = int'(a) + int'(b);
        m_rslt = W'(sum);
        m_cry  = ((sum >> W) & 1) != 0;
      end
      T_SUB: begin
        sum = int'(a) + int'(nb) + 1;
        m_rslt = W'(sum);
        m_cry  = ((sum >> W) & 1) != 0;
      end
      T_ADC: begin
        sum = int'(a) + int'(b) + (m_cry ? 1 : 0);
        m_rslt = W'(sum);
        m_cry  = ((sum >> W) & 1) != 0;
      end
      T_FLIP: begin
        m_rslt = ~a;
        m_grt = 1'b0; m_lss = 1'b0; m_eql = 1'b0;
      end
      T_CMP: begin
        o = md[0] ? num : b;
        if (md[1]) begin
          sa = int'($signed(a));
          so = int'($signed(o));
        end else begin
          sa = int'(a);
          so = int'(o);
        end
        m_grt = sa > so;
        m_lss = sa < so;
        m_eql = sa == so;
      end
      default: begin
        sh = int'(b);
        if (md == 2'b11) sh = sh % W;
        else if (sh > W) sh = W;
        case (md)
          2'b00: m_rslt = W'(int'(a) << sh);
          2'b01: m_rslt = a >> sh;
          2'b10: m_rslt = W'($signed(a) >>> sh);
          default: m_rslt = (sh == 0) ? a : W'((a >> sh) | (a << (W - sh)));
        endcase
        lat = sh + 1;
      end
    endcase
  endtask

  // Issue one op with Out_ready low, wait for the result and check it
  task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] md,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] num, input logic [W-1:0] put);
    int lat;
    int busy_cnt;
    int exp_lat;
    bus.Aluop = op; bus.Mode = md; bus.DatA = a; bus.DatB = b;
    bus.Num = num; bus.Num_to_put = put;
    bus.Out_ready = 1'b0;
    bus.In_valid  = 1'b1;
    for (int g = 0; g < 50 && !bus.In_ready; g++) begin
      @(posedge Clk); #1;
    end
    @(posedge Clk); #1;
    bus.In_valid = 1'b0;
    bus.DatA = $urandom; bus.DatB = $urandom; bus.Num = $urandom;
    model_apply(op, md, a, b, num, put, exp_lat);
    lat = 1;
    busy_cnt = 0;
    while (!bus.Out_valid && lat < 40) begin
      if (bus.Busy) busy_cnt++;
      @(posedge Clk); #1;
      lat++;
    end
    total++;
    if (bus.Out_valid !== 1'b1) begin
      bad++; $display("FAIL %s out_valid timeout: got %b want 1", tag, bus.Out_valid);
    end
    total++;
    if (bus.Rslt !== m_rslt) begin
      bad++; $display("FAIL %s rslt: got %h want %h", tag, bus.Rslt, m_rslt);
    end
    total++;
    if ({bus.Grt, bus.Lss, bus.Eql, bus.Cry} !== {m_grt, m_lss, m_eql, m_cry}) begin
      bad++; $display("FAIL %s flags GLEC: got %b want %b", tag,
                      {bus.Grt, bus.Lss, bus.Eql, bus.Cry}, {m_grt, m_lss, m_eql, m_cry});
    end
    total++;
    if (lat != exp_lat) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
    end
    total++;
    if (busy_cnt != exp_lat - 1) begin
      bad++; $display("FAIL %s busy cycles: got %0d want %0d", tag, busy_cnt, exp_lat - 1);
    end
  endtask

  task automatic consume(input string tag);
    bus.Out_ready = 1'b1;
    @(posedge Clk); #1;
    bus.Out_ready = 1'b0;
    total++;
    if (bus.Out_valid !== 1'b0) begin
      bad++; $display("FAIL %s drop after consume: got %b want 0", tag, bus.Out_valid);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    total++;
    if ({bus.Out_valid, bus.Busy, bus.In_ready} !== 3'b001) begin
      bad++; $display("FAIL %s ov/busy/ready: got %b want 001", tag,
                      {bus.Out_valid, bus.Busy, bus.In_ready});
    end
    total++;
    if (bus.Rslt !== '0) begin
      bad++; $display("FAIL %s rslt: got %h want 00", tag, bus.Rslt);
    end
    total++;
    if ({bus.Grt, bus.Lss, bus.Eql, bus.Cry} !== 4'b0000) begin
      bad++; $display("FAIL %s flags: got %b want 0000", tag,
                      {bus.Grt, bus.Lss, bus.Eql, bus.Cry});
    end
  endtask

  task automatic test_reset();
    check_idle_zero("reset_init");
    run_op("reset_pre_add", T_ADD, 2'b00, 8'hF0, 8'h20, 8'h00, 8'h00);
    consume("reset_pre_add");
    bus.Aluop = T_SHF; bus.Mode = 2'b00; bus.DatA = 8'h81; bus.DatB = 8'd5;
    bus.In_valid = 1'b1;
    @(posedge Clk); #1;
    bus.In_valid = 1'b0;
    total++;
    if (bus.Busy !== 1'b1) begin
      bad++; $display("FAIL reset_mid busy: got %b want 1", bus.Busy);
    end
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    model_reset();
    check_idle_zero("reset_mid");
    repeat (6) begin
      @(posedge Clk); #1;
    end
    check_idle_zero("reset_discard");
  endtask

  task automatic test_arith();
    run_op("add", T_ADD, 2'b00, 8'hF0, 8'h20, 8'h00, 8'h00);
    consume("add");
    run_op("adc", T_ADC, 2'b00, 8'h01, 8'h01, 8'h00, 8'h00);
    consume("adc");
    total++;
    if ({bus.Rslt, bus.Cry} !== {8'h03, 1'b0}) begin
      bad++; $display("FAIL adc_const: got %h/%b want 03/0", bus.Rslt, bus.Cry);
    end
    run_op("sub", T_SUB, 2'b00, 8'h05, 8'h07, 8'h00, 8'h00);
    consume("sub");
  endtask

  task automatic test_cmp();
    run_op("cmp_signed", T_CMP, 2'b10, 8'hFE, 8'h02, 8'h00, 8'h00);
    consume("cmp_signed");
    total++;
    if ({bus.Lss, bus.Rslt} !== {1'b1, 8'hFE}) begin
      bad++; $display("FAIL cmp_signed_const: got %b/%h want 1/fe", bus.Lss, bus.Rslt);
    end
    run_op("cmp_unsigned", T_CMP, 2'b00, 8'hFE, 8'h02, 8'h00, 8'h00);
    consume("cmp_unsigned");
    run_op("cmp_imm", T_CMP, 2'b11, 8'h80, 8'h00, 8'h7F, 8'h00);
    consume("cmp_imm");
  endtask

  task automatic test_shift();
    run_op("asr3", T_SHF, 2'b10, 8'h96, 8'd3, 8'h00, 8'h00);
    total++;
    if (bus.Rslt !== 8'hF2) begin
      bad++; $display("FAIL asr3_const: got %h want f2", bus.Rslt);
    end
    consume("asr3");
    run_op("asr12", T_SHF, 2'b10, 8'h96, 8'd12, 8'h00, 8'h00);
    consume("asr12");
    run_op("ror9", T_SHF, 2'b11, 8'h96, 8'd9, 8'h00, 8'h00);
    consume("ror9");
    run_op("lsl0", T_SHF, 2'b00, 8'h96, 8'd0, 8'h00, 8'h00);
    consume("lsl0");
    run_op("lsl8", T_SHF, 2'b00, 8'h96, 8'd8, 8'h00, 8'h00);
    consume("lsl8");
    run_op("lsr7", T_SHF, 2'b01, 8'h96, 8'd7, 8'h00, 8'h00);
    consume("lsr7");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] b;
    int lat;
    run_op("bp_put", T_PUT, 2'b00, 8'h00, 8'h00, 8'h00, 8'h5A);
    b = W'($urandom);
    bus.Aluop = T_MOV; bus.DatB = b; bus.In_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      total++;
      if ({bus.Out_valid, bus.In_ready, bus.Rslt} !== {1'b1, 1'b0, 8'h5A}) begin
        bad++; $display("FAIL bp_hold%0d ov/rdy/rslt: got %b/%b/%h want 1/0/5a",
                        i, bus.Out_valid, bus.In_ready, bus.Rslt);
      end
    end
    bus.Out_ready = 1'b1;
    #1;
    total++;
    if (bus.In_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release in_ready: got %b want 1", bus.In_ready);
    end
    @(posedge Clk); #1;
    bus.In_valid = 1'b0;
    bus.Out_ready = 1'b0;
    model_apply(T_MOV, 2'b00, 8'h00, b, 8'h00, 8'h00, lat);
    total++;
    if ({bus.Out_valid, bus.Rslt} !== {1'b1, m_rslt}) begin
      bad++; $display("FAIL bp_mov ov/rslt: got %b/%h want 1/%h", bus.Out_valid, bus.Rslt, m_rslt);
    end
    consume("bp_mov");
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [3];
    logic [1:0] mds [3];
    logic [W-1:0] as [3];
    logic [W-1:0] bs [3];
    int lat;
    ops[0] = T_MOV;  mds[0] = 2'b00; as[0] = 8'h00; bs[0] = 8'h77;
    ops[1] = T_CMP;  mds[1] = 2'b01; as[1] = 8'h33; bs[1] = 8'hC4;
    ops[2] = T_FLIP; mds[2] = 2'b00; as[2] = 8'h0F; bs[2] = 8'h00;
    bus.Out_ready = 1'b1;
    bus.Num = 8'h33;
    for (int i = 0; i < 3; i++) begin
      bus.Aluop = ops[i]; bus.Mode = mds[i]; bus.DatA = as[i]; bus.DatB = bs[i];
      bus.In_valid = 1'b1;
      #1;
      total++;
      if (bus.In_ready !== 1'b1) begin
        bad++; $display("FAIL b2b%0d in_ready: got %b want 1", i, bus.In_ready);
      end
      @(posedge Clk); #1;
      model_apply(ops[i], mds[i], as[i], bs[i], 8'h33, 8'h00, lat);
      total++;
      if ({bus.Out_valid, bus.Rslt, bus.Grt, bus.Lss, bus.Eql} !==
          {1'b1, m_rslt, m_grt, m_lss, m_eql}) begin
        bad++; $display("FAIL b2b%0d ov/rslt/GLE: got %b/%h/%b want 1/%h/%b", i,
                        bus.Out_valid, bus.Rslt, {bus.Grt, bus.Lss, bus.Eql},
                        m_rslt, {m_grt, m_lss, m_eql});
      end
    end
    bus.In_valid = 1'b0;
    total++;
    if ({bus.Rslt, bus.Eql} !== {8'hF0, 1'b0}) begin
      bad++; $display("FAIL b2b_flip_const: got %h/%b want f0/0", bus.Rslt, bus.Eql);
    end
    @(posedge Clk); #1;
    bus.Out_ready = 1'b0;
    total++;
    if (bus.Out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drain out_valid: got %b want 0", bus.Out_valid);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [1:0] md;
    logic [W-1:0] b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      md = 2'($urandom_range(0, 3));
      b  = W'($urandom);
      if (op == T_SHF && $urandom_range(0, 1) == 1) b = W'($urandom_range(0, 12));
      run_op($sformatf("rnd%0d_op%0d", i, op), op, md, W'($urandom), b,
             W'($urandom), W'($urandom));
      consume("rnd");
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    Reset_n = 1'b0;
    bus.In_valid = 1'b0; bus.Aluop = 3'd0; bus.Mode = 2'd0;
    bus.DatA = '0; bus.DatB = '0; bus.Num = '0; bus.Num_to_put = '0;
    bus.Out_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    test_reset();
    test_arith();
    test_cmp();
    test_shift();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_alu
